// File: rtl/str_tx_pkg.sv
// Shared definitions for the string transmitter and its matching receiver.
//   state_e    : sequencing FSM states (IDLE, SEND, DONE)
//   FRAME_BITS : bits per 8N1 frame (start + 8 data + stop)
//   START_BIT  : line level of the start bit
//   STOP_BIT   : line level of the stop bit, also the idle level
package str_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int   FRAME_BITS = 10;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;

endpackage

// File: rtl/str_tx_uart_tx.sv
// Single-byte 8N1 UART transmitter.
//   clk       : system clock, rising edge
//   rst       : synchronous active-high reset
//   load      : one-cycle strobe, starts a frame carrying data
//   data      : byte to send, sampled with load
//   dout      : serial line, high when no frame is active
//   active    : high while a frame is on the line
//   byte_done : one-cycle strobe in the last cycle of the stop bit;
//               a load in that same cycle chains the next frame seamlessly
module uart_tx
    import str_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       dout,
    output logic       active,
    output logic       byte_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(FRAME_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_BITS - 1);

    logic              active_q,   active_d;
    logic [7:0]        shift_q,    shift_d;
    logic [BIT_W-1:0]  bit_cnt_q,  bit_cnt_d;
    logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
    logic              bit_end;

    assign bit_end   = active_q && (baud_cnt_q == BAUD_LAST);
    assign byte_done = bit_end && (bit_cnt_q == BIT_LAST);
    assign active    = active_q;

    always_comb begin
        active_d   = active_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        baud_cnt_d = baud_cnt_q;
        if (load) begin
            active_d   = 1'b1;
            shift_d    = data;
            bit_cnt_d  = '0;
            baud_cnt_d = '0;
        end else if (active_q) begin
            if (bit_end) begin
                baud_cnt_d = '0;
                if (bit_cnt_q == BIT_LAST) begin
                    active_d  = 1'b0;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
                // shift only after a data bit, so shift_q[0] is always the bit on the line
                if (bit_cnt_q != '0) begin
                    shift_d = {1'b0, shift_q[7:1]};
                end
            end else begin
                baud_cnt_d = baud_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        dout = STOP_BIT;
        if (active_q) begin
            if (bit_cnt_q == '0) begin
                dout = START_BIT;
            end else if (bit_cnt_q == BIT_LAST) begin
                dout = STOP_BIT;
            end else begin
                dout = shift_q[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q   <= 1'b0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            baud_cnt_q <= '0;
        end else begin
            active_q   <= active_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            baud_cnt_q <= baud_cnt_d;
        end
    end

endmodule

// File: rtl/str_tx.sv
// String transmitter: sends NUM_CHARS captured characters back to back as
// 8N1 UART frames, index 0 first.
//   clk   : system clock, rising edge
//   rst   : synchronous active-high reset, aborts any transfer at once
//   start : transfer request, honoured only in IDLE or DONE
//   chars : characters to send, character i is chars[8*i+7:8*i]
//   dout  : serial line, idle high
//   busy  : high while a transfer is in progress
//   done  : one-cycle pulse after the last stop bit
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | line idle, waiting for start
// ST_SEND | frames in flight, char_idx_q names the byte on the line
// ST_DONE | one-cycle completion pulse; start here chains a new transfer
module str_tx
    import str_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int NUM_CHARS    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [8*NUM_CHARS-1:0] chars,
    output logic                   dout,
    output logic                   busy,
    output logic                   done
);

    localparam logic [4:0] LAST_IDX = 5'(NUM_CHARS - 1);

    state_e                 state_q,    state_d;
    logic [8*NUM_CHARS-1:0] chars_q,    chars_d;
    logic [4:0]             char_idx_q, char_idx_d;

    logic       tx_load;
    logic [7:0] tx_data;
    logic       tx_dout;
    logic       tx_active;
    logic       tx_byte_done;
    logic [4:0] idx_next;
    logic [7:0] next_byte;

    assign idx_next = char_idx_q + 5'd1;

    // constant-index mux keeps every read inside the capture register
    always_comb begin
        next_byte = '0;
        for (int i = 0; i < NUM_CHARS; i++) begin
            if (idx_next == 5'(i)) begin
                next_byte = chars_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        chars_d    = chars_q;
        char_idx_d = char_idx_q;
        tx_load    = 1'b0;
        tx_data    = next_byte;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    // first byte comes straight from the port since the
                    // capture register only updates at this same edge
                    state_d    = ST_SEND;
                    chars_d    = chars;
                    char_idx_d = '0;
                    tx_load    = 1'b1;
                    tx_data    = chars[7:0];
                end
            end
            ST_SEND: begin
                if (tx_byte_done) begin
                    if (char_idx_q == LAST_IDX) begin
                        state_d    = ST_DONE;
                        char_idx_d = '0;
                    end else begin
                        char_idx_d = idx_next;
                        tx_load    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            chars_q    <= '0;
            char_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            chars_q    <= chars_d;
            char_idx_q <= char_idx_d;
        end
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk       (clk),
        .rst       (rst),
        .load      (tx_load),
        .data      (tx_data),
        .dout      (tx_dout),
        .active    (tx_active),
        .byte_done (tx_byte_done)
    );

    assign dout = (state_q == ST_SEND) ? tx_dout : STOP_BIT;
    assign busy = (state_q == ST_SEND);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_str_tx.sv
// Directed bench for str_tx with CLKS_PER_BIT=4, NUM_CHARS=2.
// Edge numbering: the last edge with rst high is edge 0. A value
// "observed at edge e" is what the line shows just before edge e; an input
// "applied at edge e" is what the DUT samples at edge e.
module tb_str_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] chars = 16'h4241;
    logic        dout;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;
    int cur_e = 0;

    // hand-derived frames for 'A' (0x41) then 'B' (0x42), LSB first
    logic exp_bits [20] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                            1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    str_tx #(
        .CLKS_PER_BIT(4),
        .NUM_CHARS   (2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .chars (chars),
        .dout  (dout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s edge=%0d got=%b exp=%b", tag, cur_e, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        chars = 16'h4241;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    // mode 0 plain, 1 stray start at 40, 2 chars->FFFF at 20,
    // 3 start held (back-to-back), 4 reset at 50 then start at 60,
    // 5 rst+start together at 10 then start at 20, 6 idle only
    task automatic run_case(input int mode, input int k1, input int k2,
                            input bit has2, input int abort_e, input int last_e);
        logic eb, ed, eo;
        int   rel;
        do_reset();
        for (int e = 1; e <= last_e; e++) begin
            cur_e = e;
            eb = 1'b0;
            ed = 1'b0;
            eo = 1'b1;
            if (e > k1 && e <= k1 + 80 && (abort_e == 0 || e <= abort_e)) begin
                rel = (e - k1 - 1) / 4;
                eb  = 1'b1;
                eo  = exp_bits[rel];
            end else if (e == k1 + 81 && abort_e == 0) begin
                ed = 1'b1;
            end
            if (has2) begin
                if (e > k2 && e <= k2 + 80) begin
                    rel = (e - k2 - 1) / 4;
                    eb  = 1'b1;
                    eo  = exp_bits[rel];
                end else if (e == k2 + 81) begin
                    ed = 1'b1;
                end
            end
            chk("dout", dout, eo);
            chk("busy", busy, eb);
            chk("done", done, ed);
            start = (e == k1) || (has2 && e == k2) || (mode == 1 && e == 40) ||
                    (mode == 3 && e >= 10) || (mode == 5 && e == 10);
            rst   = (mode == 4 && e == 50) || (mode == 5 && e == 10);
            chars = (mode == 2 && e >= 20) ? 16'hFFFF : 16'h4241;
            tick();
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    initial begin
        run_case(6, 1000000, 0, 1'b0, 0, 100);
        run_case(0, 10, 0, 1'b0, 0, 95);
        run_case(1, 10, 0, 1'b0, 0, 95);
        run_case(2, 10, 0, 1'b0, 0, 95);
        run_case(3, 10, 91, 1'b1, 0, 172);
        run_case(4, 10, 60, 1'b1, 50, 145);
        run_case(5, 20, 0, 1'b0, 0, 105);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
